// File: rtl/fetch_pc_sequencer_if.sv
// PC request / instruction return bus between the fetch sequencer and the instruction loader.
// The sequencer drives requests and filters the loader's returns by epoch.
interface fetch_pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic            req_epoch;
    logic            rsp_valid;
    logic            rsp_epoch;
    logic            rsp_accept;

    modport master (
        output req_valid,
        output req_pc,
        output req_epoch,
        output rsp_accept,
        input  req_ready,
        input  rsp_valid,
        input  rsp_epoch
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  req_epoch,
        input  rsp_accept,
        output req_ready,
        output rsp_valid,
        output rsp_epoch
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: issues the PC request stream under a credit limit, applies redirects
// and tags requests with an epoch bit so stale returns are discarded.
module fetch_pc_sequencer #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter int unsigned     PC_STEP         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    fetch_pc_sequencer_if.master  bus,
    output logic [1:0]            outstanding,
    output logic                  busy
);

    localparam logic [1:0]      MaxOut = 2'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] Step   = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic [1:0]      out_q, out_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_epoch_q, req_epoch_d;
    logic            busy_q, busy_d;

    logic hs;
    logic rsp_take;
    logic held;
    logic can_issue;

    assign hs       = req_valid_q && bus.req_ready;
    // A response with nothing in flight is a leftover from before reset; ignore it.
    assign rsp_take = bus.rsp_valid && (out_q != 2'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !halt) state_d = StRun;
            StRun:   if (halt)           state_d = StDrain;
            StDrain: if (out_d == 2'd0)  state_d = StIdle;
            default:                     state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d = out_q + {1'b0, hs} - {1'b0, rsp_take};

        pc_d    = pc_q;
        epoch_d = epoch_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            epoch_d = ~epoch_q;
        end else if (hs) begin
            pc_d = req_pc_q + Step;
        end

        // A posted request survives stall; only halt, redirect or reset may withdraw it.
        held      = req_valid_q && !hs && !redirect_valid && (state_d == StRun);
        can_issue = (state_d == StRun) && !stall && (out_d < MaxOut);

        if (held) begin
            req_valid_d = 1'b1;
            req_pc_d    = req_pc_q;
            req_epoch_d = req_epoch_q;
        end else begin
            req_valid_d = can_issue;
            req_pc_d    = pc_d;
            req_epoch_d = epoch_d;
        end

        busy_d = (state_d != StIdle) || (out_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            out_q       <= 2'd0;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_PC;
            req_epoch_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epoch_q     <= epoch_d;
            out_q       <= out_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            req_epoch_q <= req_epoch_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_valid  = req_valid_q;
    assign bus.req_pc     = req_pc_q;
    assign bus.req_epoch  = req_epoch_q;
    assign bus.rsp_accept = rsp_take && (bus.rsp_epoch == epoch_q);
    assign outstanding    = out_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: expected requests and accept flags go into queues,
// a monitor pops them on every handshake / returned instruction.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  outstanding;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } req_t;

    req_t exp_req[$];
    logic exp_acc[$];

    fetch_pc_sequencer_if #(.XLEN(32)) bus ();

    fetch_pc_sequencer #(
        .XLEN            (32),
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (2),
        .PC_STEP         (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .halt           (halt),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .outstanding    (outstanding),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push_req(input logic [31:0] pc, input logic ep);
        req_t r;
        r.pc    = pc;
        r.epoch = ep;
        exp_req.push_back(r);
    endtask

    task automatic rsp(input logic v, input logic ep);
        bus.rsp_valid = v;
        bus.rsp_epoch = ep;
    endtask

    // Monitor: every handshake and every returned instruction consumes one expectation.
    initial begin
        req_t r;
        logic a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.req_valid && bus.req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_hs_pc", bus.req_pc, 32'hdead_beef);
                    end else begin
                        r = exp_req.pop_front();
                        chk("hs_pc", bus.req_pc, r.pc);
                        chk("hs_epoch", 32'(bus.req_epoch), 32'(r.epoch));
                    end
                end
                if (bus.rsp_valid) begin
                    if (exp_acc.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_accept), 32'hdead_beef);
                    end else begin
                        a = exp_acc.pop_front();
                        chk("rsp_accept", 32'(bus.rsp_accept), 32'(a));
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got %0t, expected < 20000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        bus.req_ready = 1'b0;
        rsp(1'b0, 1'b0);
        tick(); tick();

        // Reset values, then sequential fetch up to the credit limit.
        rst = 1'b0; start = 1'b1; bus.req_ready = 1'b1;
        push_req(32'h0, 1'b0); push_req(32'h4, 1'b0);
        neg();
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_req_pc", bus.req_pc, 32'h0);
        chk("rst_req_epoch", 32'(bus.req_epoch), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        neg(); chk("first_req_valid", 32'(bus.req_valid), 32'd1);
        tick();
        neg(); tick();
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b1); push_req(32'h8, 1'b0);
        neg();
        chk("credit_block_valid", 32'(bus.req_valid), 32'd0);
        chk("credit_full_out", 32'(outstanding), 32'd2);
        chk("run_busy", 32'(busy), 32'd1);
        tick();
        rsp(1'b0, 1'b0);
        neg();
        chk("after_rsp_out", 32'(outstanding), 32'd1);
        chk("after_rsp_pc", bus.req_pc, 32'h8);
        tick();

        // Held request across a stalled, not-ready loader.
        rst = 1'b1; bus.req_ready = 1'b0;
        neg(); chk("pre_reset_out", 32'(outstanding), 32'd2);
        tick();
        rst = 1'b0; start = 1'b1;
        neg(); chk("mid_reset_out", 32'(outstanding), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            start = 1'b0; stall = i[0];
            neg();
            chk("hold_valid", 32'(bus.req_valid), 32'd1);
            chk("hold_pc", bus.req_pc, 32'h0);
            tick();
        end
        stall = 1'b0; bus.req_ready = 1'b1;
        push_req(32'h0, 1'b0); push_req(32'h4, 1'b0);
        tick(); tick();

        // Redirect with two epoch-0 fetches in flight.
        redirect_valid = 1'b1; redirect_pc = 32'h100; bus.req_ready = 1'b0;
        neg();
        chk("pre_redir_out", 32'(outstanding), 32'd2);
        chk("pre_redir_valid", 32'(bus.req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b0);
        neg();
        chk("redir_req_pc", bus.req_pc, 32'h100);
        chk("redir_req_epoch", 32'(bus.req_epoch), 32'd1);
        tick();
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b0);
        neg(); chk("stale_out", 32'(outstanding), 32'd1);
        tick();
        rsp(1'b0, 1'b0); bus.req_ready = 1'b1; push_req(32'h100, 1'b1);
        neg(); chk("stale_drained_out", 32'(outstanding), 32'd0);
        tick();
        bus.req_ready = 1'b0;
        rsp(1'b1, 1'b1); exp_acc.push_back(1'b1);
        neg(); chk("next_after_redir_pc", bus.req_pc, 32'h104);
        tick();
        rsp(1'b0, 1'b0);
        neg();
        chk("new_epoch_out", 32'(outstanding), 32'd0);
        chk("run_idle_busy", 32'(busy), 32'd1);
        tick();

        // Redirect in the same cycle as the handshake of 0x8.
        rst = 1'b1; tick();
        rst = 1'b0; start = 1'b1; bus.req_ready = 1'b1;
        push_req(32'h0, 1'b0); push_req(32'h4, 1'b0);
        tick();
        start = 1'b0;
        tick(); tick();
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b1); push_req(32'h8, 1'b0);
        tick();
        rsp(1'b0, 1'b0); redirect_valid = 1'b1; redirect_pc = 32'h100;
        neg(); chk("hs_redir_pc", bus.req_pc, 32'h8);
        tick();
        redirect_valid = 1'b0;
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b0);
        neg();
        chk("hs_redir_out", 32'(outstanding), 32'd2);
        chk("hs_redir_epoch", 32'(bus.req_epoch), 32'd1);
        tick();
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b0); push_req(32'h100, 1'b1);
        tick();
        rsp(1'b0, 1'b0); bus.req_ready = 1'b0;
        neg();
        chk("hs_and_rsp_out", 32'(outstanding), 32'd1);
        chk("hold_after_pc", bus.req_pc, 32'h104);
        tick();

        // Halt with two in flight, drain, then restart sequentially.
        bus.req_ready = 1'b1; push_req(32'h104, 1'b1);
        tick();
        halt = 1'b1;
        neg(); chk("halt_out", 32'(outstanding), 32'd2);
        tick();
        rsp(1'b1, 1'b1); exp_acc.push_back(1'b1);
        neg();
        chk("drain_valid", 32'(bus.req_valid), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        tick();
        rsp(1'b1, 1'b1); exp_acc.push_back(1'b1);
        neg(); chk("drain_busy2", 32'(busy), 32'd1);
        tick();
        rsp(1'b0, 1'b0); halt = 1'b0; start = 1'b1; push_req(32'h108, 1'b1);
        neg();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_out", 32'(outstanding), 32'd0);
        chk("idle_valid", 32'(bus.req_valid), 32'd0);
        tick();
        start = 1'b0;
        neg(); chk("resume_pc", bus.req_pc, 32'h108);
        tick();

        // PC wrap at the top of the address space.
        bus.req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        neg(); chk("pre_wrap_out", 32'(outstanding), 32'd1);
        tick();
        redirect_valid = 1'b0; bus.req_ready = 1'b1; push_req(32'hFFFF_FFFC, 1'b0);
        neg(); chk("wrap_req_epoch", 32'(bus.req_epoch), 32'd0);
        tick();
        rsp(1'b1, 1'b1); exp_acc.push_back(1'b0);
        neg();
        chk("wrap_req_pc", bus.req_pc, 32'h0);
        chk("wrap_out", 32'(outstanding), 32'd2);
        tick();
        push_req(32'h0, 1'b0); rsp(1'b1, 1'b0); exp_acc.push_back(1'b1);
        tick();
        bus.req_ready = 1'b0; rsp(1'b1, 1'b0); exp_acc.push_back(1'b1);
        tick();
        rsp(1'b1, 1'b0); exp_acc.push_back(1'b0);
        neg(); chk("underflow_pre_out", 32'(outstanding), 32'd0);
        tick();
        rsp(1'b0, 1'b0); bus.req_ready = 1'b1; push_req(32'h4, 1'b0);
        neg(); chk("underflow_out", 32'(outstanding), 32'd0);
        tick();

        // Reset mid-operation; a late return must be ignored.
        bus.req_ready = 1'b0; rst = 1'b1;
        neg(); chk("mid_op_out", 32'(outstanding), 32'd1);
        tick();
        rst = 1'b0; rsp(1'b1, 1'b0); exp_acc.push_back(1'b0);
        neg();
        chk("post_rst_out", 32'(outstanding), 32'd0);
        chk("post_rst_pc", bus.req_pc, 32'h0);
        tick();
        rsp(1'b0, 1'b0);
        neg(); chk("post_rst_out2", 32'(outstanding), 32'd0);
        tick();

        chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
        chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
